// File: rtl/ps2_key_decoder_if.sv
// Byte-in / key-event-out bundle between the PS/2 receiver side (master)
// and the scan-code decoder (slave).
interface ps2_key_decoder_if #(
  parameter int unsigned COUNT_W = 8
);
  logic [7:0]         code_in;
  logic               code_valid;
  logic               ev_valid;
  logic               ev_make;
  logic               ev_ext;
  logic [7:0]         ev_code;
  logic [7:0]         ev_ascii;
  logic               ev_repeat;
  logic               held;
  logic               shift;
  logic               caps;
  logic [COUNT_W-1:0] press_cnt;
  logic               proto_err;

  modport master (
    output code_in, code_valid,
    input  ev_valid, ev_make, ev_ext, ev_code, ev_ascii, ev_repeat,
    input  held, shift, caps, press_cnt, proto_err
  );

  modport slave (
    input  code_in, code_valid,
    output ev_valid, ev_make, ev_ext, ev_code, ev_ascii, ev_repeat,
    output held, shift, caps, press_cnt, proto_err
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: strips E0/F0 prefixes, emits one registered key event
// per key action with ASCII, typematic repeat, modifier and press-count tracking.
//
//   state   | meaning
//   IDLE    | no prefix pending
//   EXT     | E0 seen, waiting for key or F0
//   BRK     | F0 seen, waiting for key to release
//   EXT_BRK | E0 F0 seen, waiting for extended key to release
module ps2_key_decoder #(
  parameter int unsigned COUNT_W = 8
) (
  input logic                clk_i,
  input logic                rst_i,
  ps2_key_decoder_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t             state_q, state_d;
  logic               ev_valid_q, ev_make_q, ev_ext_q, ev_repeat_q, proto_err_q;
  logic [7:0]         ev_code_q, ev_ascii_q;
  logic [8:0]         last_key_q;
  logic               held_q, lshift_q, rshift_q, caps_q;
  logic [COUNT_W-1:0] press_cnt_q;

  logic       is_e0, is_f0;
  logic       fire_d, err_d, make_d, ext_d;
  logic       key_match, is_repeat, upper;
  logic [7:0] ascii_d;

  assign is_e0 = (bus.code_in == 8'hE0);
  assign is_f0 = (bus.code_in == 8'hF0);

  always_comb begin
    state_d = state_q;
    fire_d  = 1'b0;
    err_d   = 1'b0;
    make_d  = 1'b1;
    ext_d   = 1'b0;
    if (bus.code_valid) begin
      case (state_q)
        IDLE: begin
          if (is_e0)      state_d = EXT;
          else if (is_f0) state_d = BRK;
          else            fire_d  = 1'b1;
        end
        EXT: begin
          if (is_f0) begin
            state_d = EXT_BRK;
          end else begin
            state_d = IDLE;
            if (is_e0) err_d = 1'b1;
            else begin
              fire_d = 1'b1;
              ext_d  = 1'b1;
            end
          end
        end
        BRK: begin
          state_d = IDLE;
          if (is_e0 || is_f0) err_d = 1'b1;
          else begin
            fire_d = 1'b1;
            make_d = 1'b0;
          end
        end
        EXT_BRK: begin
          state_d = IDLE;
          if (is_e0 || is_f0) err_d = 1'b1;
          else begin
            fire_d = 1'b1;
            make_d = 1'b0;
            ext_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign key_match = ({ext_d, bus.code_in} == last_key_q);
  assign is_repeat = make_d && held_q && key_match;
  // Case selection uses modifier state from before this event.
  assign upper     = (lshift_q | rshift_q) ^ caps_q;

  always_comb begin
    ascii_d = 8'h00;
    case (bus.code_in)
      8'h1C: ascii_d = "a";  8'h32: ascii_d = "b";  8'h21: ascii_d = "c";
      8'h23: ascii_d = "d";  8'h24: ascii_d = "e";  8'h2B: ascii_d = "f";
      8'h34: ascii_d = "g";  8'h33: ascii_d = "h";  8'h43: ascii_d = "i";
      8'h3B: ascii_d = "j";  8'h42: ascii_d = "k";  8'h4B: ascii_d = "l";
      8'h3A: ascii_d = "m";  8'h31: ascii_d = "n";  8'h44: ascii_d = "o";
      8'h4D: ascii_d = "p";  8'h15: ascii_d = "q";  8'h2D: ascii_d = "r";
      8'h1B: ascii_d = "s";  8'h2C: ascii_d = "t";  8'h3C: ascii_d = "u";
      8'h2A: ascii_d = "v";  8'h1D: ascii_d = "w";  8'h22: ascii_d = "x";
      8'h35: ascii_d = "y";  8'h1A: ascii_d = "z";
      8'h45: ascii_d = "0";  8'h16: ascii_d = "1";  8'h1E: ascii_d = "2";
      8'h26: ascii_d = "3";  8'h25: ascii_d = "4";  8'h2E: ascii_d = "5";
      8'h36: ascii_d = "6";  8'h3D: ascii_d = "7";  8'h3E: ascii_d = "8";
      8'h46: ascii_d = "9";
      8'h29: ascii_d = 8'h20;
      8'h5A: ascii_d = 8'h0D;
      8'h66: ascii_d = 8'h08;
      default: ascii_d = 8'h00;
    endcase
    if (upper && (ascii_d >= "a") && (ascii_d <= "z")) ascii_d = ascii_d - 8'h20;
    if (ext_d) ascii_d = 8'h00;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ev_valid_q  <= 1'b0;
      ev_make_q   <= 1'b0;
      ev_ext_q    <= 1'b0;
      ev_repeat_q <= 1'b0;
      proto_err_q <= 1'b0;
      ev_code_q   <= 8'h00;
      ev_ascii_q  <= 8'h00;
      last_key_q  <= 9'h000;
      held_q      <= 1'b0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_q      <= 1'b0;
      press_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ev_valid_q  <= fire_d;
      proto_err_q <= err_d;
      ev_repeat_q <= fire_d && is_repeat;
      if (fire_d) begin
        ev_make_q  <= make_d;
        ev_ext_q   <= ext_d;
        ev_code_q  <= bus.code_in;
        ev_ascii_q <= ascii_d;
        if (make_d) begin
          if (!is_repeat) begin
            last_key_q  <= {ext_d, bus.code_in};
            held_q      <= 1'b1;
            press_cnt_q <= press_cnt_q + COUNT_W'(1);
            if (!ext_d && bus.code_in == 8'h58) caps_q <= ~caps_q;
          end
        end else if (key_match) begin
          held_q <= 1'b0;
        end
        if (!ext_d && bus.code_in == 8'h12) lshift_q <= make_d;
        if (!ext_d && bus.code_in == 8'h59) rshift_q <= make_d;
      end
    end
  end

  assign bus.ev_valid  = ev_valid_q;
  assign bus.ev_make   = ev_make_q;
  assign bus.ev_ext    = ev_ext_q;
  assign bus.ev_code   = ev_code_q;
  assign bus.ev_ascii  = ev_ascii_q;
  assign bus.ev_repeat = ev_repeat_q;
  assign bus.held      = held_q;
  assign bus.shift     = lshift_q | rshift_q;
  assign bus.caps      = caps_q;
  assign bus.press_cnt = press_cnt_q;
  assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Drives two decoders (8-bit and 2-bit press counters) with directed and random
// scan-code streams, comparing against a prefix-tracking reference model.
module tb_ps2_key_decoder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ps2_key_decoder_if #(.COUNT_W(8)) bus8 ();
  ps2_key_decoder_if #(.COUNT_W(2)) bus2 ();
  assign bus2.code_in    = bus8.code_in;
  assign bus2.code_valid = bus8.code_valid;

  ps2_key_decoder #(.COUNT_W(8)) u_dut8 (.clk_i(clk), .rst_i(rst), .bus(bus8.slave));
  ps2_key_decoder #(.COUNT_W(2)) u_dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2.slave));

  int checks = 0;
  int errors = 0;

  int letter_idx [logic [7:0]];
  logic [7:0] other_map [logic [7:0]];

  // reference model state
  bit m_pext, m_pbrk, m_held, m_ls, m_rs, m_caps;
  bit m_valid, m_make, m_ext, m_rep, m_err;
  logic [8:0] m_last;
  logic [7:0] m_code, m_ascii;
  int m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_maps();
    logic [7:0] lc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                            8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                            8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] dc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    for (int i = 0; i < 26; i++) letter_idx[lc[i]] = i;
    for (int i = 0; i < 10; i++) other_map[dc[i]] = 8'(8'h30 + i);
    other_map[8'h29] = 8'h20;
    other_map[8'h5A] = 8'h0D;
    other_map[8'h66] = 8'h08;
  endtask

  function automatic logic [7:0] ref_ascii(input logic [7:0] c, input bit up);
    if (letter_idx.exists(c)) return 8'((up ? 8'h41 : 8'h61) + letter_idx[c]);
    if (other_map.exists(c)) return other_map[c];
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_pext = 0; m_pbrk = 0; m_held = 0; m_ls = 0; m_rs = 0; m_caps = 0;
    m_valid = 0; m_make = 0; m_ext = 0; m_rep = 0; m_err = 0;
    m_last = 9'h000; m_code = 8'h00; m_ascii = 8'h00; m_cnt = 0;
  endtask

  task automatic model_step(input logic [7:0] b);
    bit mk, ex;
    m_valid = 0; m_err = 0; m_rep = 0;
    if (b == 8'hE0) begin
      if (m_pext || m_pbrk) begin m_err = 1; m_pext = 0; m_pbrk = 0; end
      else m_pext = 1;
    end else if (b == 8'hF0) begin
      if (m_pbrk) begin m_err = 1; m_pext = 0; m_pbrk = 0; end
      else m_pbrk = 1;
    end else begin
      mk = !m_pbrk; ex = m_pext;
      m_pext = 0; m_pbrk = 0;
      m_valid = 1; m_make = mk; m_ext = ex; m_code = b;
      m_ascii = ex ? 8'h00 : ref_ascii(b, (m_ls || m_rs) != m_caps);
      if (mk) begin
        if (m_held && m_last == {ex, b}) m_rep = 1;
        else begin
          m_last = {ex, b}; m_held = 1; m_cnt++;
          if (!ex && b == 8'h58) m_caps = !m_caps;
        end
      end else if (m_last == {ex, b}) m_held = 0;
      if (!ex && b == 8'h12) m_ls = mk;
      if (!ex && b == 8'h59) m_rs = mk;
    end
  endtask

  task automatic check_all();
    chk("ev_valid",  32'(bus8.ev_valid),  32'(m_valid));
    chk("proto_err", 32'(bus8.proto_err), 32'(m_err));
    chk("ev_repeat", 32'(bus8.ev_repeat), 32'(m_rep));
    chk("ev_make",   32'(bus8.ev_make),   32'(m_make));
    chk("ev_ext",    32'(bus8.ev_ext),    32'(m_ext));
    chk("ev_code",   32'(bus8.ev_code),   32'(m_code));
    chk("ev_ascii",  32'(bus8.ev_ascii),  32'(m_ascii));
    chk("held",      32'(bus8.held),      32'(m_held));
    chk("shift",     32'(bus8.shift),     32'(m_ls || m_rs));
    chk("caps",      32'(bus8.caps),      32'(m_caps));
    chk("press_cnt8", 32'(bus8.press_cnt), 32'(m_cnt & 255));
    chk("press_cnt2", 32'(bus2.press_cnt), 32'(m_cnt & 3));
    chk("ev_valid2", 32'(bus2.ev_valid),  32'(m_valid));
  endtask

  task automatic strobe(input logic [7:0] b);
    bus8.code_in = b;
    bus8.code_valid = 1'b1;
    @(posedge clk);
    #1;
    model_step(b);
    check_all();
  endtask

  task automatic idle(input int n);
    bus8.code_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      m_valid = 0; m_err = 0; m_rep = 0;
      check_all();
    end
  endtask

  task automatic do_reset();
    bus8.code_valid = 1'b0;
    rst = 1'b1;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [7:0] pool [20] = '{8'hE0, 8'hF0, 8'hF0, 8'h12, 8'h59, 8'h58, 8'h1C, 8'h1C, 8'h32,
                            8'h16, 8'h29, 8'h5A, 8'h66, 8'h75, 8'h6B, 8'h1A, 8'h45, 8'h12,
                            8'hF0, 8'hE0};

  initial begin
    logic [7:0] b;
    rst = 1'b1;
    bus8.code_in = 8'h00;
    bus8.code_valid = 1'b0;
    build_maps();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_ascii", 32'(bus8.ev_ascii), 32'h0);
    rst = 1'b0;
    idle(1);

    // make / break of A
    strobe(8'h1C);
    chk("a_make_ascii", 32'(bus8.ev_ascii), 32'h61);
    chk("a_make_cnt", 32'(bus8.press_cnt), 32'd1);
    strobe(8'hF0); strobe(8'h1C);
    chk("a_brk_held", 32'(bus8.held), 32'd0);
    idle(2);

    // shift and caps
    strobe(8'h12); strobe(8'h1C);
    chk("shift_A", 32'(bus8.ev_ascii), 32'h41);
    strobe(8'hF0); strobe(8'h12); strobe(8'h58); strobe(8'h1C);
    chk("caps_A", 32'(bus8.ev_ascii), 32'h41);
    chk("caps_on", 32'(bus8.caps), 32'd1);
    strobe(8'h12); strobe(8'h1C);
    chk("shift_caps_a", 32'(bus8.ev_ascii), 32'h61);
    strobe(8'hF0); strobe(8'h12); strobe(8'h58);
    idle(1);

    // typematic repeat
    do_reset();
    strobe(8'h1C); strobe(8'h1C);
    chk("rep1", 32'(bus8.ev_repeat), 32'd1);
    strobe(8'h1C);
    chk("rep_cnt", 32'(bus8.press_cnt), 32'd1);
    strobe(8'hF0); strobe(8'h1C); strobe(8'h1C);
    chk("rep_after_brk", 32'(bus8.ev_repeat), 32'd0);
    chk("rep_cnt2", 32'(bus8.press_cnt), 32'd2);
    idle(1);

    // extended, back-to-back
    strobe(8'hE0); strobe(8'h75);
    chk("ext_flag", 32'(bus8.ev_ext), 32'd1);
    chk("ext_ascii", 32'(bus8.ev_ascii), 32'h0);
    strobe(8'hE0); strobe(8'hF0); strobe(8'h75);
    chk("ext_brk_held", 32'(bus8.held), 32'd0);
    idle(1);

    // protocol errors
    strobe(8'hF0); strobe(8'hF0);
    chk("err_ff", 32'(bus8.proto_err), 32'd1);
    strobe(8'h1C);
    chk("after_err_make", 32'(bus8.ev_make), 32'd1);
    strobe(8'hE0); strobe(8'hE0);
    chk("err_ee", 32'(bus8.proto_err), 32'd1);
    idle(1);

    // counter wrap on the 2-bit instance
    do_reset();
    strobe(8'h1C); chk("wrap1", 32'(bus2.press_cnt), 32'd1);
    strobe(8'h32); chk("wrap2", 32'(bus2.press_cnt), 32'd2);
    strobe(8'h21); chk("wrap3", 32'(bus2.press_cnt), 32'd3);
    strobe(8'h23); chk("wrap0", 32'(bus2.press_cnt), 32'd0);
    idle(1);

    // reset mid-sequence discards prefix
    strobe(8'hE0);
    do_reset();
    strobe(8'h29);
    chk("rst_mid_valid", 32'(bus8.ev_valid), 32'd1);
    chk("rst_mid_ext", 32'(bus8.ev_ext), 32'd0);
    chk("rst_mid_ascii", 32'(bus8.ev_ascii), 32'h20);
    idle(1);

    // randomized stream
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(0, 255));
      else b = pool[$urandom_range(0, 19)];
      strobe(b);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
